// File: rtl/state_dump_unit_pkg.sv
// Shared definitions for the end-of-run state dump: default geometry, stream kind
// codes and FSM encoding, so the core and the dump block agree on sizes.
package state_dump_unit_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREG  = 32;
   localparam int DEF_NMEM  = 64;
   localparam int RF_ADDR_W = 5;

   localparam logic KIND_REG = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DUMP = 2'd1,
      ST_DONE = 2'd2
   } dump_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/state_dump_unit_out_reg.sv
// One-entry valid/ready holding register for the dump stream: load takes priority,
// clear drops valid after a handshake, otherwise the entry holds.
module dump_out_reg
   import state_dump_unit_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int IDX_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [XLEN-1:0]  in_data,
   input  logic             in_kind,
   input  logic [IDX_W-1:0] in_index,
   input  logic             in_last,
   output logic             valid,
   output logic [XLEN-1:0]  data,
   output logic             kind,
   output logic [IDX_W-1:0] index,
   output logic             last
);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         kind  <= KIND_REG;
         index <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         kind  <= in_kind;
         index <= in_index;
         last  <= in_last;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/state_dump_unit.sv
// Post-halt dump of the register file then data memory as a valid/ready word stream;
// borrows the core's combinational read ports only while dumping.
module state_dump_unit
   import state_dump_unit_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int NREG = DEF_NREG,
   parameter int NMEM = DEF_NMEM,
   localparam int TOTAL = NREG + NMEM,
   localparam int PTR_W = $clog2(TOTAL + 1),
   localparam int IDX_W = $clog2(max_int(NREG, NMEM))
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 halt,
   input  logic                 rearm,
   output logic [RF_ADDR_W-1:0] rf_rd_addr,
   input  logic [XLEN-1:0]      rf_rd_data,
   output logic [IDX_W-1:0]     dm_rd_addr,
   input  logic [XLEN-1:0]      dm_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_data,
   output logic                 out_kind,
   output logic [IDX_W-1:0]     out_index,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   dump_state_t      state, state_next;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] mem_off;
   logic             in_dump;
   logic             sel_mem;
   logic             load;
   logic             clear;
   logic             accept_last;
   logic [XLEN-1:0]  word;
   logic [IDX_W-1:0] word_index;

   always_comb begin
      in_dump     = (state == ST_DUMP);
      sel_mem     = (ptr >= PTR_W'(NREG));
      mem_off     = ptr - PTR_W'(NREG);
      load        = in_dump && (!out_valid || out_ready) && (ptr < PTR_W'(TOTAL));
      clear       = in_dump && out_valid && out_ready && !load;
      accept_last = in_dump && out_valid && out_ready && out_last;
      word        = sel_mem ? dm_rd_data : rf_rd_data;
      word_index  = sel_mem ? IDX_W'(mem_off) : IDX_W'(ptr);
   end

   // The inactive read port is parked at 0 so the core sees a quiet bus.
   always_comb begin
      rf_rd_addr = '0;
      dm_rd_addr = '0;
      if (in_dump) begin
         if (sel_mem) dm_rd_addr = IDX_W'(mem_off);
         else         rf_rd_addr = RF_ADDR_W'(ptr);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: if (halt) state_next = ST_DUMP;
         ST_DUMP: begin
            busy = 1'b1;
            if (accept_last) state_next = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (rearm) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ptr is zeroed whenever not dumping, so every dump starts at register 0.
   always_ff @(posedge clock) begin
      if (reset || !in_dump) ptr <= '0;
      else if (load)         ptr <= ptr + 1'b1;
   end

   dump_out_reg #(
      .XLEN  (XLEN),
      .IDX_W (IDX_W)
   ) u_out_reg (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .clear    (clear),
      .in_data  (word),
      .in_kind  (sel_mem),
      .in_index (word_index),
      .in_last  (ptr == PTR_W'(TOTAL - 1)),
      .valid    (out_valid),
      .data     (out_data),
      .kind     (out_kind),
      .index    (out_index),
      .last     (out_last)
   );

endmodule
